// File: rtl/risc16_ba.sv
// risc16_ba: 4-stage RISC16 core, IF/RF/EX/WB.
// Split instruction/data buses, byte-addressed data.
module risc16_ba #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] idin,
  output logic [15:0] iaddr,
  output logic        ioe,
  input  logic [15:0] ddin,
  output logic [15:0] ddout,
  output logic [15:0] daddr,
  output logic        doe,
  output logic        dwe0,
  output logic        dwe1
);

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00110;
  localparam logic [4:0] OP_ORI  = 5'b00111;
  localparam logic [4:0] OP_LLI  = 5'b01000;
  localparam logic [4:0] OP_LUI  = 5'b01001;
  localparam logic [4:0] OP_BNEZ = 5'b10000;
  localparam logic [4:0] OP_BEQZ = 5'b10001;
  localparam logic [4:0] OP_BMI  = 5'b10010;
  localparam logic [4:0] OP_BPL  = 5'b10011;
  localparam logic [4:0] OP_J    = 5'b11000;

  localparam logic [4:0] F_MV  = 5'b00001;
  localparam logic [4:0] F_NOT = 5'b00010;
  localparam logic [4:0] F_XOR = 5'b00011;
  localparam logic [4:0] F_ADD = 5'b00100;
  localparam logic [4:0] F_SUB = 5'b00101;
  localparam logic [4:0] F_AND = 5'b00110;
  localparam logic [4:0] F_OR  = 5'b00111;
  localparam logic [4:0] F_SL8 = 5'b01000;
  localparam logic [4:0] F_SR8 = 5'b01001;
  localparam logic [4:0] F_SL  = 5'b01010;
  localparam logic [4:0] F_SR  = 5'b01011;
  localparam logic [4:0] F_ST  = 5'b10000;
  localparam logic [4:0] F_LD  = 5'b10001;
  localparam logic [4:0] F_SBU = 5'b10010;
  localparam logic [4:0] F_LBU = 5'b10011;

  // True when an instruction writes its rd field.
  function automatic logic writes_rd(
    input logic [4:0] op,
    input logic [4:0] func
  );
    logic w;
    w = 1'b0;
    if (op == OP_R) begin
      case (func)
        F_MV, F_NOT, F_XOR, F_ADD,
        F_SUB, F_AND, F_OR, F_SL8,
        F_SR8, F_SL, F_SR, F_LD,
        F_LBU:   w = 1'b1;
        default: w = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI,
        OP_LLI, OP_LUI: w = 1'b1;
        default:        w = 1'b0;
      endcase
    end
    return w;
  endfunction

  logic [15:0] if_pc;
  logic [15:0] if_ir;
  logic [15:0] if_ipc;
  logic [15:0] rf_ir;
  logic [15:0] rf_pc;
  logic [15:0] rf_a;
  logic [15:0] rf_b;
  logic        ex_we;
  logic [2:0]  ex_rd;
  logic [15:0] ex_result;
  logic [15:0] regs [8];

  logic [4:0]  op;
  logic [4:0]  func;
  logic [15:0] sext8;
  logic [15:0] zext8;
  logic [15:0] sext11;
  logic [15:0] ex_val;
  logic        ex_wr;
  logic        take;
  logic [15:0] target;
  logic [2:0]  rd_idx;
  logic [2:0]  rs_idx;
  logic [15:0] opa;
  logic [15:0] opb;

  assign iaddr  = if_pc;
  assign op     = rf_ir[15:11];
  assign func   = rf_ir[4:0];
  assign sext8  = {{8{rf_ir[7]}}, rf_ir[7:0]};
  assign zext8  = {8'h00, rf_ir[7:0]};
  assign sext11 = {{5{rf_ir[10]}}, rf_ir[10:0]};
  assign ex_wr  = writes_rd(op, func);
  assign rd_idx = if_ir[10:8];
  assign rs_idx = if_ir[7:5];

  // Operand read with bypass: EX result first, then pending WB.
  always_comb begin
    opa = regs[rd_idx];
    opb = regs[rs_idx];
    if (ex_wr && rf_ir[10:8] == rd_idx)
      opa = ex_val;
    else if (ex_we && ex_rd == rd_idx)
      opa = ex_result;
    if (ex_wr && rf_ir[10:8] == rs_idx)
      opb = ex_val;
    else if (ex_we && ex_rd == rs_idx)
      opb = ex_result;
  end

  // EX: ALU, branch resolution and the data-bus transaction.
  always_comb begin
    ex_val = '0;
    take   = 1'b0;
    target = rf_pc + 16'd2 + sext8;
    daddr  = '0;
    ddout  = '0;
    doe    = 1'b0;
    dwe0   = 1'b0;
    dwe1   = 1'b0;
    if (op == OP_R) begin
      unique case (func)
        F_MV:  ex_val = rf_b;
        F_NOT: ex_val = ~rf_b;
        F_XOR: ex_val = rf_a ^ rf_b;
        F_ADD: ex_val = rf_a + rf_b;
        F_SUB: ex_val = rf_a - rf_b;
        F_AND: ex_val = rf_a & rf_b;
        F_OR:  ex_val = rf_a | rf_b;
        F_SL8: ex_val = {rf_b[7:0], 8'h00};
        F_SR8: ex_val = {8'h00, rf_b[15:8]};
        F_SL:  ex_val = {rf_b[14:0], 1'b0};
        F_SR:  ex_val = {1'b0, rf_b[15:1]};
        F_ST: begin
          daddr = rf_b;
          ddout = rf_a;
          dwe0  = 1'b1;
          dwe1  = 1'b1;
        end
        F_LD: begin
          daddr  = rf_b;
          doe    = 1'b1;
          ex_val = ddin;
        end
        F_SBU: begin
          daddr = rf_b;
          ddout = {rf_a[7:0], rf_a[7:0]};
          dwe0  = ~rf_b[0];
          dwe1  = rf_b[0];
        end
        F_LBU: begin
          daddr  = rf_b;
          doe    = 1'b1;
          ex_val = rf_b[0] ? {8'h00, ddin[7:0]}
                           : {8'h00, ddin[15:8]};
        end
        default: ex_val = '0;
      endcase
    end else begin
      unique case (op)
        OP_ADDI: ex_val = rf_a + sext8;
        OP_ANDI: ex_val = rf_a & zext8;
        OP_ORI:  ex_val = rf_a | zext8;
        OP_LLI:  ex_val = zext8;
        OP_LUI:  ex_val = {rf_ir[7:0], 8'h00};
        OP_BNEZ: take = (rf_a != 16'h0000);
        OP_BEQZ: take = (rf_a == 16'h0000);
        OP_BMI:  take = rf_a[15];
        OP_BPL:  take = ~rf_a[15];
        OP_J: begin
          take   = 1'b1;
          target = rf_pc + 16'd2 + sext11;
        end
        default: ex_val = '0;
      endcase
    end
  end

  // Pipeline advance; a taken branch squashes IF and RF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc     <= RESET_PC;
      ioe       <= 1'b0;
      if_ir     <= NOP;
      if_ipc    <= RESET_PC;
      rf_ir     <= NOP;
      rf_pc     <= '0;
      rf_a      <= '0;
      rf_b      <= '0;
      ex_we     <= 1'b0;
      ex_rd     <= '0;
      ex_result <= '0;
    end else begin
      ioe <= 1'b1;
      if (take)
        if_pc <= target;
      else if (ioe)
        if_pc <= if_pc + 16'd2;
      if_ir     <= (take || !ioe) ? NOP : idin;
      if_ipc    <= if_pc;
      rf_ir     <= take ? NOP : if_ir;
      rf_pc     <= if_ipc;
      rf_a      <= opa;
      rf_b      <= opb;
      ex_we     <= ex_wr;
      ex_rd     <= rf_ir[10:8];
      ex_result <= ex_val;
    end
  end

  // Register file write from WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else if (ex_we) begin
      regs[ex_rd] <= ex_result;
    end
  end

endmodule

// File: tb/tb_risc16_ba.sv
// tb_risc16_ba: runs a directed program on a byte memory model,
// scoreboards every data-bus transaction against hand values.
module tb_risc16_ba;

  localparam logic [4:0] LLI  = 5'b01000;
  localparam logic [4:0] LUI  = 5'b01001;
  localparam logic [4:0] ADDI = 5'b00100;
  localparam logic [4:0] ORI  = 5'b00111;
  localparam logic [4:0] BNEZ = 5'b10000;
  localparam logic [4:0] BEQZ = 5'b10001;
  localparam logic [4:0] BMI  = 5'b10010;
  localparam logic [4:0] BPL  = 5'b10011;
  localparam logic [4:0] MV   = 5'b00001;
  localparam logic [4:0] NOTF = 5'b00010;
  localparam logic [4:0] XORF = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] SUB  = 5'b00101;
  localparam logic [4:0] ANDF = 5'b00110;
  localparam logic [4:0] ORF  = 5'b00111;
  localparam logic [4:0] SL8  = 5'b01000;
  localparam logic [4:0] SR8  = 5'b01001;
  localparam logic [4:0] SL   = 5'b01010;
  localparam logic [4:0] SR   = 5'b01011;
  localparam logic [4:0] ST   = 5'b10000;
  localparam logic [4:0] LD   = 5'b10001;
  localparam logic [4:0] SBU  = 5'b10010;
  localparam logic [4:0] LBU  = 5'b10011;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  we;
    logic        oe;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] idin;
  logic [15:0] iaddr;
  logic        ioe;
  logic [15:0] ddin;
  logic [15:0] ddout;
  logic [15:0] daddr;
  logic        doe;
  logic        dwe0;
  logic        dwe1;

  logic [7:0]  mem [65536];
  txn_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] pa;

  always #5 clk = ~clk;

  risc16_ba #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .idin  (idin),
    .iaddr (iaddr),
    .ioe   (ioe),
    .ddin  (ddin),
    .ddout (ddout),
    .daddr (daddr),
    .doe   (doe),
    .dwe0  (dwe0),
    .dwe1  (dwe1)
  );

  assign idin = {mem[{iaddr[15:1], 1'b0}],
                 mem[{iaddr[15:1], 1'b1}]};
  assign ddin = {mem[{daddr[15:1], 1'b0}],
                 mem[{daddr[15:1], 1'b1}]};

  // Byte-lane write port of the memory model.
  always @(posedge clk) begin
    if (dwe0) mem[{daddr[15:1], 1'b0}] <= ddout[15:8];
    if (dwe1) mem[{daddr[15:1], 1'b1}] <= ddout[7:0];
  end

  // Monitor: every bus transaction pops one expectation.
  always @(negedge clk) begin
    txn_t e;
    logic ok;
    if (rst && (doe || dwe0 || dwe1)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL bus_extra addr=%h dout=%h we=%b%b oe=%b exp=none",
                 daddr, ddout, dwe0, dwe1, doe);
      end else begin
        e  = q.pop_front();
        ok = (daddr == e.addr) && (doe == e.oe) &&
             ({dwe0, dwe1} == e.we) &&
             (e.oe || ddout == e.data);
        if (!ok) begin
          errors++;
          $display("FAIL bus_txn got addr=%h dout=%h we=%b%b oe=%b exp addr=%h dout=%h we=%b oe=%b",
                   daddr, ddout, dwe0, dwe1, doe,
                   e.addr, e.data, e.we, e.oe);
        end
      end
    end
  end

  function automatic logic [15:0] rr(
    input logic [2:0] d, input logic [2:0] s,
    input logic [4:0] f);
    return {5'b00000, d, s, f};
  endfunction

  function automatic logic [15:0] ii(
    input logic [4:0] o, input logic [2:0] d,
    input logic [7:0] m);
    return {o, d, m};
  endfunction

  function automatic logic [15:0] jj(input logic [10:0] m);
    return {5'b11000, m};
  endfunction

  task automatic emit(input logic [15:0] w);
    mem[pa]         <= w[15:8];
    mem[pa + 16'd1] <= w[7:0];
    pa = pa + 16'd2;
  endtask

  task automatic ew(input logic [15:0] a, input logic [15:0] d,
                    input logic [1:0] we);
    txn_t t;
    t.addr = a; t.data = d; t.we = we; t.oe = 1'b0;
    q.push_back(t);
  endtask

  task automatic er(input logic [15:0] a);
    txn_t t;
    t.addr = a; t.data = '0; t.we = 2'b00; t.oe = 1'b1;
    q.push_back(t);
  endtask

  task automatic chk(input string n, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic load_prog;
    pa = 16'h0000;
    emit(ii(LLI, 1, 8'h34));  emit(ii(LUI, 2, 8'h12));
    emit(rr(1, 2, ORF));      emit(ii(LUI, 3, 8'hC0));
    emit(rr(1, 3, ST));       emit(rr(4, 3, LD));
    emit(ii(ADDI, 4, 8'h01)); emit(ii(LUI, 6, 8'h02));
    emit(rr(4, 6, ST));       emit(ii(ADDI, 1, 8'hFF));
    emit(ii(ORI, 6, 8'h02));  emit(rr(1, 6, ST));
    emit(rr(7, 1, MV));       emit(rr(7, 2, SUB));
    emit(rr(7, 1, XORF));     emit(rr(0, 7, NOTF));
    emit(rr(0, 6, ST));       emit(rr(0, 1, SL));
    emit(rr(5, 0, SR8));      emit(rr(5, 6, ST));
    emit(rr(5, 0, ADD));      emit(rr(5, 0, ANDF));
    emit(rr(5, 6, ST));       emit(rr(5, 5, SL8));
    emit(rr(4, 0, SR));       emit(rr(4, 5, ADD));
    emit(rr(4, 6, ST));       emit(ii(ORI, 3, 8'h03));
    emit(ii(LLI, 1, 8'hAB));  emit(rr(1, 3, SBU));
    emit(rr(5, 3, LBU));      emit(ii(ADDI, 5, 8'h01));
    emit(rr(5, 6, ST));       emit(ii(ADDI, 3, 8'hFF));
    emit(rr(4, 3, LD));       emit(rr(4, 6, ST));
    emit(rr(4, 3, LBU));      emit(rr(4, 6, ST));
    emit(ii(LLI, 7, 8'h00));  emit(ii(BEQZ, 7, 8'h04));
    emit(rr(1, 6, ST));       emit(rr(1, 6, ST));
    emit(ii(BNEZ, 7, 8'h04)); emit(rr(7, 6, ST));
    emit(ii(LUI, 2, 8'h80));  emit(ii(BPL, 2, 8'h02));
    emit(rr(2, 6, ST));       emit(ii(BMI, 2, 8'h02));
    emit(rr(1, 6, ST));       emit(ii(LLI, 4, 8'h03));
    emit(rr(4, 6, ST));       emit(ii(ADDI, 4, 8'hFF));
    emit(ii(BEQZ, 4, 8'h04)); emit(jj(11'h7F8));
    emit(rr(1, 6, ST));       emit(rr(4, 6, ST));
    emit(jj(11'h7FE));
    for (int i = 0; i < 4; i++) emit(16'h0000);
  endtask

  task automatic push_all;
    ew(16'hC000, 16'h1234, 2'b11); er(16'hC000);
    ew(16'h0200, 16'h1235, 2'b11);
    ew(16'h0202, 16'h1233, 2'b11);
    ew(16'h0202, 16'hEDFF, 2'b11);
    ew(16'h0202, 16'h0024, 2'b11);
    ew(16'h0202, 16'h2402, 2'b11);
    ew(16'h0202, 16'h1433, 2'b11);
    ew(16'hC003, 16'hABAB, 2'b01); er(16'hC003);
    ew(16'h0202, 16'h00AC, 2'b11); er(16'hC002);
    ew(16'h0202, 16'h5AAB, 2'b11); er(16'hC002);
    ew(16'h0202, 16'h005A, 2'b11);
    ew(16'h0202, 16'h0000, 2'b11);
    ew(16'h0202, 16'h8000, 2'b11);
    ew(16'h0202, 16'h0003, 2'b11);
    ew(16'h0202, 16'h0002, 2'b11);
    ew(16'h0202, 16'h0001, 2'b11);
    ew(16'h0202, 16'h0000, 2'b11);
  endtask

  task automatic check_reset(input string n);
    chk({n, "_iaddr"}, iaddr, 16'h0000);
    chk({n, "_ioe"}, {15'd0, ioe}, 16'h0000);
    chk({n, "_doe"}, {15'd0, doe}, 16'h0000);
    chk({n, "_dwe"}, {14'd0, dwe0, dwe1}, 16'h0000);
    chk({n, "_daddr"}, daddr, 16'h0000);
    chk({n, "_ddout"}, ddout, 16'h0000);
  endtask

  task automatic check_fetch;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fetch_iaddr", iaddr, 16'(i * 2));
      chk("fetch_ioe", {15'd0, ioe}, 16'h0001);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 500; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
  endtask

  initial begin
    load_prog;
    mem[16'hC002] <= 8'h5A;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    push_all;
    check_fetch;
    drain;
    repeat (10) @(negedge clk);

    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset("rst_halt");
    @(negedge clk);
    rst = 1'b1;
    push_all;
    check_fetch;
    repeat (9) @(negedge clk);

    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset("rst_mid");
    q.delete();
    repeat (2) @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b1;
    push_all;
    check_fetch;
    drain;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc16_ba.md
Name: risc16_ba

Overview:
- 16-bit pipelined RISC16 processor core with separate instruction and data buses and byte-addressable data memory.
- Pipeline: IF (fetch) → RF (decode/register read) → EX (ALU, memory access) → WB (register write).
- Connects directly to an external dual-port byte memory. Data address 0x200/0x202 is memory-mapped LED I/O decoded outside the core.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- idin  in  16  instruction word: {mem[iaddr&~1], mem[iaddr|1]} (big-endian).
- iaddr  out  16  instruction address (= if_pc).
- ioe  out  1  instruction read enable.
- ddin  in  16  data read word, big-endian, valid in the same cycle as daddr/doe.
- ddout  out  16  data write word.
- daddr  out  16  data byte address.
- doe  out  1  data read enable.
- dwe0  out  1  write ddout[15:8] to the even byte (daddr&~1).
- dwe1  out  1  write ddout[7:0] to the odd byte (daddr|1).

Behaviour:
- Reset (rst=0, async):
  - if_pc=RESET_PC; ioe=0.
  - All pipeline instruction registers (if_ir, rf_ir, ex_ir) = NOP (16'h0000).
  - r0..r7=0; doe=dwe0=dwe1=0; daddr=0; ddout=0.
- After reset: ioe=1 constantly; iaddr=if_pc. Each cycle: if_ir<=idin, if_pc<=if_pc+2 (wraps 0xFFFE→0).
- Instruction formats:
  - R-type: [15:11]=00000, rd=[10:8], rs=[7:5], func=[4:0].
  - I-type: op=[15:11], rd=[10:8], imm8=[7:0].
  - J: op=11000, imm11=[10:0].
- R funcs:
  - 00000 NOP; 00001 MV rd=rs; 00010 NOT rd=~rs; 00011 XOR; 00100 ADD; 00101 SUB rd=rd-rs.
  - 00110 AND; 00111 OR; 01000 SL8 rd=rs<<8; 01001 SR8 rd=rs>>8; 01010 SL rd=rs<<1; 01011 SR rd=rs>>1 (all shifts logical).
  - 10000 ST mem16[rs]=rd; 10001 LD rd=mem16[rs]; 10010 SBU mem8[rs]=rd[7:0]; 10011 LBU rd=zext(mem8[rs]).
  - Unlisted funcs behave as NOP.
- I ops:
  - 00100 ADDI rd+=sext(imm8); 00110 ANDI rd&=zext; 00111 ORI rd|=zext.
  - 01000 LLI rd=zext(imm8); 01001 LUI rd={imm8,8'h00}.
  - 10000 BNEZ (rd≠0); 10001 BEQZ (rd=0); 10010 BMI (rd[15]=1); 10011 BPL (rd[15]=0).
  - 11000 J (unconditional). Unlisted opcodes are NOP.
- Arithmetic: 16-bit modulo; no flags.
- Branch/jump targets: branch PC+2+sext(imm8); J PC+2+sext(imm11), where PC is the address of the branch/jump instruction.
- Branch resolution:
  - Resolved in EX. When taken, if_pc<=target at the end of EX, and the instructions in IF and RF are squashed to NOP.
  - 2-cycle penalty; no delay slots.
- Memory access (combinational in EX):
  - daddr=rs value.
  - LD/LBU: doe=1.
  - ST: dwe0=dwe1=1, ddout=rd.
  - SBU: ddout={rd[7:0],rd[7:0]}; dwe0=~daddr[0], dwe1=daddr[0].
  - LBU: selects ddin[15:8] if daddr[0]=0, else ddin[7:0], zero-extended.
  - All enables are 0 for other instructions.
- Writeback:
  - EX result latched into ex_result/ex_ir; register written on the next edge.
  - r0 is a normal writable register.
- Hazards, no stalls ever:
  - RF read operands are forwarded from the EX-stage result (including load data) and from the pending WB result.
  - Priority: EX > WB > register file.
- Simultaneous taken branch and younger dependent instructions: squashed instructions never write registers or memory.

Test Plan:
- Reset/fetch: hold rst=0 then release → iaddr 0,2,4,... one per cycle; ioe=1; doe/dwe0/dwe1=0.
- ALU + forwarding: LLI r1,0x34; LUI r2,0x12; OR r1,r2 back-to-back → r1=0x1234. Then ADDI r1,-1 → 0x1233; SUB/XOR/NOT/SL/SR8 against golden values.
- Word memory: ST r1,(r3) with r3=0xC000, r1=0x1234 → mem[C000]=12, mem[C001]=34; LD r4,(r3) → r4=0x1234.
- Byte memory, even and odd address:
  - SBU r1,(r3) with r3=0xC003, r1=0x00AB → only dwe1 asserted, mem[C003]=AB, mem[C002] unchanged.
  - LBU r5 from 0xC003 → r5=0x00AB.
  - Load-use in the next instruction gets the correct data.
- Branches:
  - BEQZ on r=0 with imm8=+4 → the 2 following instructions are not executed, fetch resumes at PC+6.
  - BNEZ not taken → sequential execution.
  - BMI/BPL on 0x8000.
  - J with negative offset loops.
- Write to LED address: ST to 0x200 and 0x202 → dwe0/dwe1 asserted with the correct ddout.
- Async reset mid-run: pc returns to 0 and no spurious writes occur.
